// File: rtl/cascade_pkg.sv
// Shared types and sizing helpers for the cascaded subtractor datapath.
package cascade_pkg;

  localparam int DATA_W = 16;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  localparam int HALF_W = half_w(DATA_W);

  typedef struct packed {
    logic [HALF_W-1:0] diff;
    logic              borrow;
  } half_res_t;

  typedef logic [DATA_W-1:0] cnt_t;

endpackage

// File: rtl/cascade_sub_half.sv
// Combinational half-width subtractor: diff = a - b - bi, bo set on unsigned underflow.
module sub_half #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  // One extra bit catches the borrow: the result is never below -2^W.
  logic [W:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
  assign diff = full[W-1:0];
  assign bo   = full[W];

endmodule

// File: rtl/cascade_sub.sv
// Two-stage pipelined cascaded subtractor with loadable down-counter and match comparator.
// Optional signed-overflow output enabled by defining CASCADE_SUB_OVF_EN.
module cascade_sub
  import cascade_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_zero,
  output logic             match
);

  localparam int H = half_w(WIDTH);

  if ((WIDTH != DATA_W) || (CNT_W != WIDTH) || ((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_cfg
    $error("cascade_sub: WIDTH must equal DATA_W and CNT_W, be even and >= 4");
  end

  logic         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic         s1_load, s2_load;
  logic [H-1:0] s1_dl_q, s1_ah_q, s1_bh_q;
  logic         s1_bl_q;
  logic [WIDTH-1:0] d_q;
  logic         bout_q;
  cnt_t         cnt_q, cnt_d;
  half_res_t    lo_res, hi_res;

  sub_half #(.W(H)) u_lo (
    .a(data1[H-1:0]), .b(data2[H-1:0]), .bi(bin),
    .diff(lo_res.diff), .bo(lo_res.borrow)
  );

  sub_half #(.W(H)) u_hi (
    .a(s1_ah_q), .b(s1_bh_q), .bi(s1_bl_q),
    .diff(hi_res.diff), .bo(hi_res.borrow)
  );

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Pipeline occupancy and counter next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (load) begin
      cnt_d = load_val;
    end else if (start && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stage 1: low-half difference plus the high halves it still needs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_dl_q <= '0;
      s1_bl_q <= 1'b0;
      s1_ah_q <= '0;
      s1_bh_q <= '0;
    end else if (s1_load) begin
      s1_dl_q <= lo_res.diff;
      s1_bl_q <= lo_res.borrow;
      s1_ah_q <= data1[WIDTH-1:H];
      s1_bh_q <= data2[WIDTH-1:H];
    end
  end

  // Stage 2: assemble the full difference; held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (s2_load) begin
      d_q    <= {hi_res.diff, s1_dl_q};
      bout_q <= hi_res.borrow;
    end
  end

`ifdef CASCADE_SUB_OVF_EN
  logic s1_sa_q, s1_sb_q, ovf_q;

  // Sign bits travel with stage 1 and resolve into ovf alongside d
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sa_q <= 1'b0;
      s1_sb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_sa_q <= data1[WIDTH-1];
        s1_sb_q <= data2[WIDTH-1];
      end
      if (s2_load) begin
        ovf_q <= (s1_sa_q != s1_sb_q) && (hi_res.diff[H-1] != s1_sa_q);
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = s2_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign cnt       = cnt_q;
  assign cnt_zero  = (cnt_q == '0);
  assign match     = s2_valid_q && (d_q == cnt_q);

endmodule
